// File: rtl/onij_psum_accumulator.sv
// Accumulates OFIFO rows into PSUM SRAM for one kernel position, remapping input index nij
// to output index onij, with saturating add and optional ReLU on the last kernel position.
module onij_psum_accumulator #(
    parameter int Col    = 8,
    parameter int PsumBw = 16,
    parameter int InW    = 6,
    parameter int OutW   = 4,
    parameter int Ks     = 3,
    parameter int LenNij = 36
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [3:0]            kij_i,
    input  logic [10:0]           oc_base_i,
    input  logic                  relu_en_i,
    input  logic                  ofifo_valid_i,
    input  logic [Col*PsumBw-1:0] ofifo_out_i,
    output logic                  ofifo_rd_o,
    output logic                  pmem_cen_o,
    output logic                  pmem_wen_o,
    output logic [10:0]           pmem_addr_o,
    output logic [Col*PsumBw-1:0] pmem_d_o,
    input  logic [Col*PsumBw-1:0] pmem_q_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int RowW = Col * PsumBw;
    localparam int NijW = $clog2(LenNij + 1);
    localparam logic [NijW-1:0] NijEnd = NijW'(LenNij);

    typedef enum logic [2:0] {StIdle, StPop, StRd, StWr, StDone} state_e;

    state_e            state_q, state_d;
    logic [NijW-1:0]   nij_q, nij_d, nij_inc;
    logic [RowW-1:0]   row_q, row_d;
    logic [10:0]       addr_q, addr_d;
    logic [3:0]        kij_q, kij_d;
    logic [10:0]       base_q, base_d;
    logic              relu_q, relu_d;

    logic              map_valid;
    logic [10:0]       map_addr;
    logic [RowW-1:0]   wdata;
    logic [PsumBw-1:0] lane_row, lane_mem, lane_res;

    assign nij_inc = nij_q + 1'b1;

    function automatic logic [PsumBw-1:0] sat_add(input logic [PsumBw-1:0] a,
                                                  input logic [PsumBw-1:0] b);
        logic [PsumBw:0] s;
        s = {a[PsumBw-1], a} + {b[PsumBw-1], b};
        if (s[PsumBw] != s[PsumBw-1]) begin
            sat_add = s[PsumBw] ? {1'b1, {(PsumBw-1){1'b0}}} : {1'b0, {(PsumBw-1){1'b1}}};
        end else begin
            sat_add = s[PsumBw-1:0];
        end
    endfunction

    // nij -> onij for the latched kernel position; kij > 8 never maps.
    always_comb begin
        int x, y, kx, ky, ox, oy;
        x  = int'(nij_q) % InW;
        y  = int'(nij_q) / InW;
        kx = int'(kij_q) % Ks;
        ky = int'(kij_q) / Ks;
        ox = x - kx;
        oy = y - ky;
        map_valid = (kij_q <= 4'd8) && (ox >= 0) && (ox < OutW) && (oy >= 0) && (oy < OutW);
        map_addr  = base_q + 11'(oy * OutW + ox);
    end

    always_comb begin
        kij_d  = kij_q;
        base_d = base_q;
        relu_d = relu_q;
        nij_d  = nij_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (state_q == StIdle && start_i) begin
            kij_d  = kij_i;
            base_d = oc_base_i;
            relu_d = relu_en_i;
            nij_d  = '0;
        end
        if (state_q == StPop && ofifo_valid_i) begin
            row_d  = ofifo_out_i;
            addr_d = map_addr;
            nij_d  = nij_inc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            nij_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            kij_q   <= '0;
            base_q  <= '0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nij_q   <= nij_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            kij_q   <= kij_d;
            base_q  <= base_d;
            relu_q  <= relu_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StPop;
            StPop: begin
                if (ofifo_valid_i) begin
                    if (!map_valid) state_d = (nij_inc == NijEnd) ? StDone : StPop;
                    else if (kij_q == 4'd0) state_d = StWr;
                    else state_d = StRd;
                end
            end
            StRd:   state_d = StWr;
            StWr:   state_d = (nij_q == NijEnd) ? StDone : StPop;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ofifo_rd_o = 1'b0;
        pmem_cen_o = 1'b1;
        pmem_wen_o = 1'b1;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        unique case (state_q)
            StPop: begin
                busy_o     = 1'b1;
                ofifo_rd_o = ofifo_valid_i;
            end
            StRd: begin
                busy_o     = 1'b1;
                pmem_cen_o = 1'b0;
            end
            StWr: begin
                busy_o     = 1'b1;
                pmem_cen_o = 1'b0;
                pmem_wen_o = 1'b0;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    // pmem_q_i carries the read issued in RD, so it is only meaningful while in WR.
    always_comb begin
        wdata    = '0;
        lane_row = '0;
        lane_mem = '0;
        lane_res = '0;
        for (int l = 0; l < Col; l++) begin
            lane_row = row_q[l*PsumBw +: PsumBw];
            lane_mem = pmem_q_i[l*PsumBw +: PsumBw];
            lane_res = (kij_q == 4'd0) ? lane_row : sat_add(lane_mem, lane_row);
            if (kij_q == 4'd8 && relu_q && lane_res[PsumBw-1]) lane_res = '0;
            wdata[l*PsumBw +: PsumBw] = lane_res;
        end
    end

    assign pmem_addr_o = addr_q;
    assign pmem_d_o    = (state_q == StWr) ? wdata : '0;

endmodule

// File: doc/onij_psum_accumulator.md
# onij_psum_accumulator

Sequential accumulation stage between the core's OFIFO and the PSUM SRAM. For one kernel position (kij), it pops each OFIFO row and maps the row's input index nij to an output index onij. It then either writes the row to PSUM SRAM (kij 0) or read-modify-writes it (kij 1..8). Rows that fall outside the output map are discarded. An optional ReLU is applied on the final kij.

## Interface
Parameters:
- col, 8, lanes per OFIFO row
- psum_bw, 16, signed bits per lane
- in_w, 6, input feature-map width (nij = y*in_w + x)
- out_w, 4, output feature-map width (in_w - ks + 1)
- ks, 3, kernel width
- len_nij, 36, rows per pass (in_w*in_w)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a pass
- kij  in  4  kernel index 0..8; sampled on start
- oc_base  in  11  PSUM base address for this output-channel group; sampled on start
- relu_en  in  1  sampled on start; ReLU applied to stored results when kij==8
- ofifo_valid  in  1  OFIFO holds at least one complete row
- ofifo_out  in  col*psum_bw  head row, lane 0 in LSBs; valid while ofifo_valid
- ofifo_rd  out  1  pop strobe
- pmem_cen  out  1  PSUM chip enable, active-low
- pmem_wen  out  1  PSUM write enable, active-low
- pmem_addr  out  11  PSUM address
- pmem_d  out  col*psum_bw  PSUM write data
- pmem_q  in  col*psum_bw  PSUM read data, valid the cycle after a read request
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse when the pass completes

## Operation
- States: IDLE, POP, RD, WR, DONE.
- IDLE:
  - On start, latch kij, oc_base and relu_en; clear nij to 0; go to POP.
  - start while busy is ignored.
  - kij>8 is treated as a discard-all pass: every row is popped, no SRAM access is made.
- POP:
  - Waits while ofifo_valid=0.
  - When ofifo_valid=1: ofifo_rd=1 for that cycle; register ofifo_out into row_r; compute onij from the current nij; then increment nij.
- onij mapping:
  - x = nij % in_w, y = nij / in_w, kx = kij % ks, ky = kij / ks.
  - ox = x - kx, oy = y - ky.
  - Valid iff 0 ≤ ox < out_w and 0 ≤ oy < out_w; addr = oc_base + oy*out_w + ox.
- Next state after POP:
  - Invalid row: go to POP, or to DONE if nij has reached len_nij.
  - Valid row, kij==0: go to WR, with passthrough write data = row_r.
  - Valid row, kij≠0: go to RD.
- RD: pmem_cen=0, pmem_wen=1, pmem_addr=addr; go to WR.
- WR:
  - pmem_cen=0, pmem_wen=0, pmem_addr=addr.
  - pmem_d per lane = sat(pmem_q_lane + row_r_lane) when kij≠0, otherwise row_r_lane.
  - Arithmetic: signed psum_bw+1-bit add, saturated to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - If kij==8 and relu_en, negative lanes are written as 0.
  - Next state: POP, or DONE if nij==len_nij.
- DONE: done=1 for one cycle, busy=0; go to IDLE.
- Reset (any state, including mid-pass): go to IDLE; clear nij and row_r. Partial SRAM contents are left as they are.

## Timing
- Reset values:
  - ofifo_rd=0, pmem_cen=1, pmem_wen=1, pmem_addr=0, pmem_d=0, busy=0, done=0.
- All outputs are registered or decoded from the state only. No output depends combinationally on ofifo_valid except ofifo_rd in POP.
- Latency per popped row (from the pop cycle to the next possible pop):
  - Invalid row: 1 cycle.
  - kij==0: 2 cycles (POP, WR).
  - kij≠0: 3 cycles (POP, RD, WR).
- Only one SRAM access per cycle; reads and writes never overlap.
- No address hazard: the nij→onij mapping is injective for a fixed kij.
- The block never pops an empty OFIFO: ofifo_rd=1 only when ofifo_valid=1 in POP.
- done is asserted exactly one cycle after the WR or POP that consumed row len_nij-1.
- busy rises the cycle after start and falls in the DONE cycle.

## Test plan
- **kij=0 passthrough.** oc_base=0; 36 rows with lane value = nij.
  - Exactly 16 writes, each with no preceding read.
  - Write order is addr 0..15; addr 0 holds 0, addr 5 holds 7, addr 15 holds 21.
  - done arrives after the 36th pop.
- **kij=4 accumulate.** SRAM preloaded with 100 at all 16 addresses; all rows carry 1; oc_base=16.
  - The first valid row is nij=7, written to addr 16.
  - Every address 16..31 holds 101 and receives one RD then one WR.
  - nij 0..6 are discarded with no SRAM activity.
- **Saturation.** SRAM lane holds 32760; row lane holds 20; kij=1 → 32767 written. SRAM holds -32760, row holds -20 → -32768 written.
- **ReLU.** kij=8, relu_en=1; SRAM holds -5, row holds 2 → 0 written. SRAM holds 5, row holds 2 → 7 written. With relu_en=0, the first case writes -3.
- **Backpressure.** Hold ofifo_valid=0 for 10 cycles mid-pass.
  - Stays in POP with ofifo_rd=0, pmem_cen=1, busy=1.
  - Resumes on valid with no row lost or duplicated.
- **Reset mid-pass.** Assert reset during RD at nij=20.
  - The next cycle shows all outputs at reset values and busy=0.
  - A new start with kij=0 completes normally.
  - A start pulse during busy is ignored.
